dot_product_16_8x8: RTL and testbench

DOT_PRODUCT_16_8X8 -- requirements
Module: dot_product_16_8x8

---
 rtl/dot_product_16_8x8.sv | 181 ++++++++++++++++++
 tb/tb_dot_product_16_8x8.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_16_8x8.sv
// dot_product_16_8x8
//   Streaming signed dot-product engine. Each compute cycle multiplies 16
//   signed 8-bit A elements by 16 signed 8-bit B elements and adds the 16
//   products. The B elements are read from an internal 1024 x 64-bit memory
//   as an even/odd word pair. Terms are accumulated into a 48-bit result
//   between i_first and i_last. The result is presented four edges after
//   i_last is sampled.
//
// Ports
//   i_clk      : sole clock, rising edge
//   i_reset_n  : asynchronous active-low reset (release synchronised inside)
//   i_a        : 16 x signed 8-bit A elements, element k = i_a[8k+7:8k]
//   i_b        : 8 x signed 8-bit B elements written on write cycles
//   i_b_addr   : 64-bit B-memory word address (write and read)
//   i_wren     : 1 = write cycle, 0 = compute cycle
//   i_first    : first term of a dot product (compute cycles only)
//   i_last     : last term of a dot product (compute cycles only)
//   o_sum      : signed accumulated dot product, held between results
//   o_valid    : one-cycle strobe qualifying a new o_sum
module dot_product_16_8x8 #(
    localparam int N = 8,
    localparam int M = 16,
    localparam int A = 10,
    localparam int S = 48
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [M*N-1:0]       i_a,
    input  logic [(M/2)*N-1:0]   i_b,
    input  logic [A-1:0]         i_b_addr,
    input  logic                 i_wren,
    input  logic                 i_first,
    input  logic                 i_last,
    output logic signed [S-1:0]  o_sum,
    output logic                 o_valid
);

    localparam int W = (M / 2) * N;   // memory word width, 64 bits

    // Signed sum of eight 8x8 products; 20 bits cannot overflow.
    function automatic logic signed [19:0] dot8(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [19:0] sum;
        logic signed [15:0] prod;
        sum = 20'sd0;
        for (int k = 0; k < 8; k++) begin
            prod = 16'($signed(a[N*k +: N])) * 16'($signed(b[N*k +: N]));
            sum  = sum + 20'(prod);
        end
        return sum;
    endfunction

    logic                rst_sync_r;
    logic                rst_n_s;
    logic [W-1:0]        mem_r [0:(1<<A)-1];
    logic [W-1:0]        rd_lo_r;
    logic [W-1:0]        rd_hi_r;
    logic [M*N-1:0]      a_s1_r;
    logic                s1_vld_r, s1_first_r, s1_last_r;
    logic signed [19:0]  psum_lo_r, psum_hi_r;
    logic                s2_vld_r, s2_first_r, s2_last_r;
    logic signed [S-1:0] term_r;
    logic                s3_vld_r, s3_first_r, s3_last_r;
    logic signed [S-1:0] acc_r;
    logic signed [S-1:0] acc_nxt_s;
    logic                active_r;
    logic                active_nxt_s;
    logic                done_s;
    logic                done_r;

    // Reset synchroniser: assertion is immediate, release lands on one edge
    // so the first compute cycle is accepted on the second edge after release.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_r <= 1'b0;
        end else begin
            rst_sync_r <= 1'b1;
        end
    end

    assign rst_n_s = rst_sync_r;

    // B memory write port; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wren) begin
            mem_r[i_b_addr] <= i_b;
        end
    end

    // Stage 1 datapath: read the even/odd word pair and delay A to match.
    always_ff @(posedge i_clk) begin
        rd_lo_r <= mem_r[{i_b_addr[A-1:1], 1'b0}];
        rd_hi_r <= mem_r[{i_b_addr[A-1:1], 1'b1}];
        a_s1_r  <= i_a;
    end

    // Stages 2-3 datapath: half-sums, then the full 48-bit term.
    always_ff @(posedge i_clk) begin
        psum_lo_r <= dot8(a_s1_r[W-1:0],     rd_lo_r);
        psum_hi_r <= dot8(a_s1_r[M*N-1:W],   rd_hi_r);
        term_r    <= S'(psum_lo_r + psum_hi_r);
    end

    // Control pipeline; write cycles enter as bubbles so first/last are ignored.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            s1_vld_r   <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s2_vld_r   <= 1'b0;
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s3_vld_r   <= 1'b0;
            s3_first_r <= 1'b0;
            s3_last_r  <= 1'b0;
        end else begin
            s1_vld_r   <= ~i_wren;
            s1_first_r <= i_first & ~i_wren;
            s1_last_r  <= i_last & ~i_wren;
            s2_vld_r   <= s1_vld_r;
            s2_first_r <= s1_first_r;
            s2_last_r  <= s1_last_r;
            s3_vld_r   <= s2_vld_r;
            s3_first_r <= s2_first_r;
            s3_last_r  <= s2_last_r;
        end
    end

    // Accumulate decision: first reloads, active adds, otherwise the term is dropped.
    always_comb begin
        acc_nxt_s    = acc_r;
        active_nxt_s = active_r;
        done_s       = 1'b0;
        if (s3_vld_r) begin
            if (s3_first_r) begin
                acc_nxt_s    = term_r;
                active_nxt_s = ~s3_last_r;
                done_s       = s3_last_r;
            end else if (active_r) begin
                acc_nxt_s    = acc_r + term_r;
                active_nxt_s = ~s3_last_r;
                done_s       = s3_last_r;
            end else begin
                acc_nxt_s    = acc_r;
                active_nxt_s = 1'b0;
                done_s       = 1'b0;
            end
        end else begin
            acc_nxt_s    = acc_r;
            active_nxt_s = active_r;
            done_s       = 1'b0;
        end
    end

    // Accumulator, active flag and end-of-product marker.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            acc_r    <= {S{1'b0}};
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            acc_r    <= acc_nxt_s;
            active_r <= active_nxt_s;
            done_r   <= done_s;
        end
    end

    // Output register: o_sum only changes when a result is strobed.
    always_ff @(posedge i_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            o_sum   <= {S{1'b0}};
            o_valid <= 1'b0;
        end else begin
            o_valid <= done_r;
            if (done_r) begin
                o_sum <= acc_r;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_16_8x8.sv
// tb_dot_product_16_8x8
//   Directed vectors with hand-computed results, followed by a randomised
//   stream checked against a signed reference model.
module tb_dot_product_16_8x8;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic [127:0] i_a;
    logic [63:0]  i_b;
    logic [9:0]   i_b_addr;
    logic         i_wren;
    logic         i_first;
    logic         i_last;
    logic [47:0]  o_sum;
    logic         o_valid;

    dot_product_16_8x8 dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_b_addr  (i_b_addr),
        .i_wren    (i_wren),
        .i_first   (i_first),
        .i_last    (i_last),
        .o_sum     (o_sum),
        .o_valid   (o_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor: one entry per cycle that o_valid is high.
    logic [47:0] got_sum [$];
    int          got_cyc [$];
    always @(negedge clk) begin
        if (o_valid) begin
            got_sum.push_back(o_sum);
            got_cyc.push_back(cyc);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic wren, input logic [127:0] a, input logic [63:0] b,
                         input logic [9:0] addr, input logic first, input logic last);
        i_wren   = wren;
        i_a      = a;
        i_b      = b;
        i_b_addr = addr;
        i_first  = first;
        i_last   = last;
        @(negedge clk);
    endtask

    // Writes drive first/last high to show they are ignored.
    task automatic wr(input logic [9:0] addr, input logic [63:0] data);
        drive(1'b1, 128'd0, data, addr, 1'b1, 1'b1);
    endtask

    task automatic comp(input logic [127:0] a, input logic [9:0] addr, input logic first, input logic last);
        drive(1'b0, a, 64'd0, addr, first, last);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 128'd0, 64'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic clear_mon();
        got_sum.delete();
        got_cyc.delete();
    endtask

    function automatic logic [47:0] ref_term(input logic [127:0] a, input logic [127:0] b);
        longint s;
        s = 64'sd0;
        for (int k = 0; k < 16; k++) begin
            s = s + longint'($signed(a[8*k +: 8])) * longint'($signed(b[8*k +: 8]));
        end
        return s[47:0];
    endfunction

    localparam logic [127:0] A01 = {16{8'h01}};
    localparam logic [127:0] A02 = {16{8'h02}};
    localparam logic [127:0] A03 = {16{8'h03}};
    localparam logic [127:0] A80 = {16{8'h80}};
    localparam logic [127:0] AFF = {16{8'hFF}};

    logic [127:0] a_idx;
    logic [63:0]  bm [0:15];
    logic [47:0]  exp_q [$];
    logic [47:0]  macc;
    logic         mact;
    int           lc;
    int           n_cmp;

    initial begin
        i_reset_n = 1'b1;
        i_a = 128'd0; i_b = 64'd0; i_b_addr = 10'd0;
        i_wren = 1'b0; i_first = 1'b0; i_last = 1'b0;
        for (int k = 0; k < 16; k++) a_idx[8*k +: 8] = 8'(k);

        // Reset state
        #2 i_reset_n = 1'b0;
        @(negedge clk);
        check_val("rst_sum", o_sum, 48'd0);
        check_val("rst_valid", 48'(o_valid), 48'd0);
        @(negedge clk);
        i_reset_n = 1'b1;
        idle(3);

        // Single-term product of ones: 16, four edges after i_last
        clear_mon();
        wr(10'd0, {8{8'h01}});
        wr(10'd1, {8{8'h01}});
        comp(A01, 10'd0, 1'b1, 1'b1);
        lc = cyc;
        idle(8);
        check_val("t1_count", 48'(got_sum.size()), 48'd1);
        if (got_sum.size() > 0) begin
            check_val("t1_sum", got_sum[0], 48'd16);
            check_val("t1_latency", 48'(got_cyc[0]), 48'(lc + 4));
        end
        check_val("t1_hold", o_sum, 48'd16);

        // Three terms of -128*127 over 16 lanes
        wr(10'd2, {8{8'h7F}});
        wr(10'd3, {8{8'h7F}});
        clear_mon();
        comp(A80, 10'd2, 1'b1, 1'b0);
        comp(A80, 10'd3, 1'b0, 1'b0);
        comp(A80, 10'd2, 1'b0, 1'b1);
        idle(8);
        check_val("t2_count", 48'(got_sum.size()), 48'd1);
        if (got_sum.size() > 0) check_val("t2_sum", got_sum[0], -48'sd780288);

        // Back-to-back 2-term products: 48, -258064, 6080
        clear_mon();
        comp(A01, 10'd0, 1'b1, 1'b0);
        comp(A02, 10'd0, 1'b0, 1'b1);
        lc = cyc;
        comp(A80, 10'd2, 1'b1, 1'b0);
        comp(A01, 10'd2, 1'b0, 1'b1);
        comp(AFF, 10'd0, 1'b1, 1'b0);
        comp(A03, 10'd2, 1'b0, 1'b1);
        idle(8);
        check_val("t3_count", 48'(got_sum.size()), 48'd3);
        if (got_sum.size() > 2) begin
            check_val("t3_sum0", got_sum[0], 48'd48);
            check_val("t3_sum1", got_sum[1], -48'sd258064);
            check_val("t3_sum2", got_sum[2], 48'd6080);
            check_val("t3_lat0", 48'(got_cyc[0]), 48'(lc + 4));
            check_val("t3_gap01", 48'(got_cyc[1] - got_cyc[0]), 48'd2);
            check_val("t3_gap12", 48'(got_cyc[2] - got_cyc[1]), 48'd2);
        end

        // Writes inside an active product; last read uses the fresh words.
        // 16 + (0+..+7)*1 + (8+..+15)*(-1) = 16 + 28 - 92 = -48
        clear_mon();
        comp(A01, 10'd0, 1'b1, 1'b0);
        wr(10'd4, {8{8'h01}});
        wr(10'd5, {8{8'hFF}});
        comp(a_idx, 10'd4, 1'b0, 1'b1);
        idle(8);
        check_val("t4_count", 48'(got_sum.size()), 48'd1);
        if (got_sum.size() > 0) check_val("t4_sum", got_sum[0], -48'sd48);

        // i_last with nothing active
        clear_mon();
        comp(A01, 10'd0, 1'b0, 1'b1);
        idle(8);
        check_val("t5_count", 48'(got_sum.size()), 48'd0);

        // Reset between first and last aborts the product
        clear_mon();
        comp(A01, 10'd0, 1'b1, 1'b0);
        comp(A01, 10'd0, 1'b0, 1'b0);
        i_reset_n = 1'b0;
        #1;
        check_val("t6_rst_sum", o_sum, 48'd0);
        check_val("t6_rst_valid", 48'(o_valid), 48'd0);
        @(negedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
        idle(3);
        comp(A01, 10'd0, 1'b0, 1'b1);
        idle(8);
        check_val("t6_count", 48'(got_sum.size()), 48'd0);
        check_val("t6_sum", o_sum, 48'd0);

        // Random regression against the reference model
        for (int w = 8; w < 16; w++) begin
            bm[w] = {$urandom, $urandom};
            wr(10'(w), bm[w]);
        end
        clear_mon();
        macc = 48'd0;
        mact = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                int w;
                w = $urandom_range(8, 15);
                bm[w] = {$urandom, $urandom};
                wr(10'(w), bm[w]);
            end else begin
                int ad, ev;
                logic [127:0] ra;
                logic [47:0]  t;
                logic         f, l;
                ad = $urandom_range(8, 15);
                ev = (ad / 2) * 2;
                ra = {$urandom, $urandom, $urandom, $urandom};
                f  = ($urandom_range(0, 3) == 0);
                l  = ($urandom_range(0, 2) == 0);
                t  = ref_term(ra, {bm[ev + 1], bm[ev]});
                if (f) begin
                    macc = t;
                    mact = !l;
                    if (l) exp_q.push_back(macc);
                end else if (mact) begin
                    macc = macc + t;
                    if (l) begin
                        mact = 1'b0;
                        exp_q.push_back(macc);
                    end
                end
                comp(ra, 10'(ad), f, l);
            end
        end
        idle(8);
        check_val("rnd_count", 48'(got_sum.size()), 48'(exp_q.size()));
        n_cmp = (got_sum.size() < exp_q.size()) ? got_sum.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            check_val($sformatf("rnd_sum%0d", i), got_sum[i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
